// File: rtl/alu_pkg.sv
// Purpose: shared definitions for the ALU issue sequencer.
//   - ALU select codes driven on alu_s
//   - FSM state encoding, also presented on the sequencer's dbg_state output
package alu_pkg;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_t;

endpackage

// File: rtl/alu_regfile.sv
// Purpose: register file for the ALU issue sequencer.
// Ports:
//   clk, rst                  clock, asynchronous active-high clear of every entry
//   i_rs1_addr / o_rs1_data   asynchronous read port 1
//   i_rs2_addr / o_rs2_data   asynchronous read port 2
//   i_ld_en/addr/data         direct load write port
//   i_wb_en/addr/data         result writeback port (wins over load on same address)
// Entry 0 always reads as zero and ignores both write ports.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] i_rs1_addr,
  output logic [DATA_WIDTH-1:0] o_rs1_data,
  input  logic [ADDR_WIDTH-1:0] i_rs2_addr,
  output logic [DATA_WIDTH-1:0] o_rs2_data,
  input  logic                  i_ld_en,
  input  logic [ADDR_WIDTH-1:0] i_ld_addr,
  input  logic [DATA_WIDTH-1:0] i_ld_data,
  input  logic                  i_wb_en,
  input  logic [ADDR_WIDTH-1:0] i_wb_addr,
  input  logic [DATA_WIDTH-1:0] i_wb_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Entry 0 is never written after reset; loop starts at 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        if (i_wb_en && (i_wb_addr == ADDR_WIDTH'(i))) begin
          r_mem[i] <= i_wb_data;
        end else if (i_ld_en && (i_ld_addr == ADDR_WIDTH'(i))) begin
          r_mem[i] <= i_ld_data;
        end
      end
    end
  end

  // Reads see pre-edge contents: a load in the same cycle is not bypassed.
  assign o_rs1_data = (i_rs1_addr == '0) ? '0 : r_mem[i_rs1_addr];
  assign o_rs2_data = (i_rs2_addr == '0) ? '0 : r_mem[i_rs2_addr];

endmodule

// File: rtl/alu_op_sequencer.sv
// Purpose: issue side of a 2-bit-select ALU. Accepts register-form ops,
//   reads operands from the internal register file, drives the external ALU,
//   captures its result, writes it back and presents it on a response port.
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   in_valid/in_ready               request handshake; in_op, in_rd, in_rs1, in_rs2 fields
//   ld_en/ld_addr/ld_data           direct register load, accepted in any state
//   alu_a/alu_b/alu_s               registered ALU operands and select
//   alu_c                           combinational ALU result
//   out_valid/out_ready             response handshake; out_rd, out_data fields
//   ops_done                        count of completed response handshakes (wraps)
//   dbg_state                       current FSM state (alu_pkg::state_t encoding)
// Handshakes: a transfer happens on a rising edge where valid and ready are
//   both high. Once out_valid is raised it stays high, with out_rd/out_data
//   stable, until that transfer; in_ready is high only in IDLE and never
//   during reset.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_op,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  input  logic [ADDR_WIDTH-1:0] in_rs1,
  input  logic [ADDR_WIDTH-1:0] in_rs2,
  input  logic                  ld_en,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_data,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [1:0]            alu_s,
  input  logic [DATA_WIDTH-1:0] alu_c,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_rd,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CNT_WIDTH-1:0]  ops_done,
  output logic [1:0]            dbg_state
);

  state_t                r_state;
  state_t                w_next;
  logic                  w_in_ready;
  logic                  w_accept;
  logic                  w_wb_en;
  logic                  w_resp_done;

  logic [ADDR_WIDTH-1:0] r_rd;
  logic [DATA_WIDTH-1:0] r_alu_a;
  logic [DATA_WIDTH-1:0] r_alu_b;
  logic [1:0]            r_alu_s;
  logic                  r_out_valid;
  logic [ADDR_WIDTH-1:0] r_out_rd;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic [CNT_WIDTH-1:0]  r_ops_done;

  logic [DATA_WIDTH-1:0] w_rs1_data;
  logic [DATA_WIDTH-1:0] w_rs2_data;

  alu_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_regfile (
    .clk        (clk),
    .rst        (rst),
    .i_rs1_addr (in_rs1),
    .o_rs1_data (w_rs1_data),
    .i_rs2_addr (in_rs2),
    .o_rs2_data (w_rs2_data),
    .i_ld_en    (ld_en),
    .i_ld_addr  (ld_addr),
    .i_ld_data  (ld_data),
    .i_wb_en    (w_wb_en),
    .i_wb_addr  (r_rd),
    .i_wb_data  (alu_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_in_ready  = 1'b0;
    w_accept    = 1'b0;
    w_wb_en     = 1'b0;
    w_resp_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_in_ready = 1'b1;
        if (in_valid) begin
          w_accept = 1'b1;
          w_next   = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // Register 0 is masked in the regfile as well; gating here keeps the
        // write strobe itself meaningful.
        w_wb_en = (r_rd != '0);
        w_next  = ST_RESP;
      end
      ST_RESP: begin
        // out_valid is always high in RESP, so out_ready alone completes it.
        if (out_ready) begin
          w_resp_done = 1'b1;
          w_next      = ST_IDLE;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // ALU operand registers only change on accept, so they hold outside EXEC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alu_a <= '0;
      r_alu_b <= '0;
      r_alu_s <= '0;
      r_rd    <= '0;
    end else if (w_accept) begin
      r_alu_a <= w_rs1_data;
      r_alu_b <= w_rs2_data;
      r_alu_s <= in_op;
      r_rd    <= in_rd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_rd    <= '0;
      r_out_data  <= '0;
      r_ops_done  <= '0;
    end else begin
      if (r_state == ST_EXEC) begin
        r_out_valid <= 1'b1;
        r_out_rd    <= r_rd;
        r_out_data  <= alu_c;
      end else if (w_resp_done) begin
        r_out_valid <= 1'b0;
        r_ops_done  <= r_ops_done + 1'b1;
      end
    end
  end

  assign in_ready  = w_in_ready & ~rst;
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_s     = r_alu_s;
  assign out_valid = r_out_valid;
  assign out_rd    = r_out_rd;
  assign out_data  = r_out_data;
  assign ops_done  = r_ops_done;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;
  import alu_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    in_op = '0;
  logic [AW-1:0] in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic          ld_en = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_data = '0;
  logic [DW-1:0] alu_a, alu_b, alu_c;
  logic [1:0]    alu_s;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [AW-1:0] out_rd;
  logic [DW-1:0] out_data;
  logic [CW-1:0] ops_done;
  logic [1:0]    dbg_state;

  alu_op_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_s     (alu_s),
    .alu_c     (alu_c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_rd    (out_rd),
    .out_data  (out_data),
    .ops_done  (ops_done),
    .dbg_state (dbg_state)
  );

  // ---------------- reference model ----------------
  function automatic logic [DW-1:0] alu_ref(input logic [1:0] s, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    case (s)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      default: return a | b;
    endcase
  endfunction

  // External ALU attached to the sequencer.
  assign alu_c = alu_ref(alu_s, alu_a, alu_b);

  logic [DW-1:0] m_rf [32];
  int            m_ops = 0;
  logic [DW-1:0] exp_q [$];
  int            last_accept = -100;

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    m_ops = 0;
    exp_q.delete();
  endtask

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks (called 1 time unit after a rising edge) ----------------
  task automatic do_ld(input logic [AW-1:0] a, input logic [DW-1:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
    if (a != '0) m_rf[a] = d;
  endtask

  task automatic do_op(input logic [1:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] rs1,
                       input logic [AW-1:0] rs2, input int hold, input bit collide,
                       input bit ld_same, input bit chk_gap, output logic [DW-1:0] res);
    int            waitc;
    int            acc;
    logic [DW-1:0] exp;
    logic [DW-1:0] snap_d;
    logic [DW-1:0] snap_a;
    logic [DW-1:0] ld_v;
    waitc = 0;
    while (!in_ready && waitc < 20) begin
      @(posedge clk); #1; waitc++;
    end
    check("in_ready_wait", {31'b0, in_ready}, 32'd1);
    exp = alu_ref(op, m_rf[rs1], m_rf[rs2]);
    exp_q.push_back(exp);
    in_valid = 1'b1; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    ld_v = $urandom;
    if (ld_same) begin
      ld_en = 1'b1; ld_addr = rs1; ld_data = ld_v;
    end
    @(posedge clk); #1;
    acc = cyc;
    in_valid = 1'b0; ld_en = 1'b0;
    if (ld_same && rs1 != '0) m_rf[rs1] = ld_v;
    if (chk_gap) check("issue_gap", acc - last_accept, 32'd3);
    last_accept = acc;
    check("exec_in_ready", {31'b0, in_ready}, 32'd0);
    check("exec_out_valid", {31'b0, out_valid}, 32'd0);
    if (collide) begin
      ld_en = 1'b1; ld_addr = rd; ld_data = $urandom;
    end
    @(posedge clk); #1;
    ld_en = 1'b0;
    if (rd != '0) m_rf[rd] = exp;  // writeback beats a colliding load
    check("resp_out_valid", {31'b0, out_valid}, 32'd1);
    check("resp_out_data", out_data, exp_q.pop_front());
    check("resp_out_rd", {27'b0, out_rd}, {27'b0, rd});
    res    = out_data;
    snap_d = out_data;
    snap_a = alu_a;
    // Hold off the consumer while offering a second request that must not be taken.
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; in_op = ~op; in_rs1 = rs2; in_rs2 = rs1;
      @(posedge clk); #1;
      check("hold_out_valid", {31'b0, out_valid}, 32'd1);
      check("hold_out_data", out_data, snap_d);
      check("hold_in_ready", {31'b0, in_ready}, 32'd0);
      check("hold_alu_a", alu_a, snap_a);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    m_ops++;
    check("hs_out_valid", {31'b0, out_valid}, 32'd0);
    check("hs_ops_done", {16'b0, ops_done}, m_ops & 32'hFFFF);
  endtask

  // Observe a register through an OR with r0 into r0 (no writeback).
  task automatic read_reg(input logic [AW-1:0] r, input logic [DW-1:0] exp, input string tag);
    logic [DW-1:0] v;
    do_op(ALU_OR, '0, r, '0, 0, 1'b0, 1'b0, 1'b0, v);
    check(tag, v, exp);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [DW-1:0] r;
    model_clear();

    // Reset state
    #2;
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_ops_done", {16'b0, ops_done}, 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_state", {30'b0, dbg_state}, {30'b0, ST_IDLE});
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

    // Add wrap
    do_ld(5'd1, 32'hFFFF_FFFF);
    do_ld(5'd2, 32'h2);
    do_op(ALU_ADD, 5'd3, 5'd1, 5'd2, 0, 1'b0, 1'b0, 1'b0, r);
    check("add_wrap", r, 32'h1);
    read_reg(5'd3, 32'h1, "rf3_after_add");

    // Sub / and / or
    do_ld(5'd1, 32'h5);
    do_ld(5'd2, 32'h7);
    do_op(ALU_SUB, 5'd6, 5'd1, 5'd2, 0, 1'b0, 1'b0, 1'b0, r);
    check("sub", r, 32'hFFFF_FFFE);
    do_op(ALU_AND, 5'd7, 5'd1, 5'd2, 0, 1'b0, 1'b0, 1'b0, r);
    check("and", r, 32'h5);
    do_op(ALU_OR, 5'd8, 5'd1, 5'd2, 0, 1'b0, 1'b0, 1'b0, r);
    check("or", r, 32'h7);

    // Backpressure for 10 cycles
    do_op(ALU_SUB, 5'd11, 5'd2, 5'd1, 10, 1'b0, 1'b0, 1'b0, r);
    check("bp_sub", r, 32'h2);

    // rd = 0 result presented but discarded; load/writeback collision
    do_op(ALU_ADD, 5'd0, 5'd1, 5'd2, 0, 1'b0, 1'b0, 1'b0, r);
    check("rd0_result", r, 32'd12);
    read_reg(5'd0, 32'h0, "rf0_zero");
    do_op(ALU_ADD, 5'd9, 5'd1, 5'd2, 0, 1'b1, 1'b0, 1'b0, r);
    read_reg(5'd9, 32'd12, "wb_beats_ld");

    // Load in the accept cycle is not bypassed into the operand
    do_op(ALU_OR, 5'd10, 5'd1, 5'd0, 0, 1'b0, 1'b1, 1'b0, r);
    check("no_bypass", r, 32'h5);

    // Back-to-back dependency with out_ready promptly high
    do_ld(5'd1, 32'h3);
    do_op(ALU_ADD, 5'd4, 5'd1, 5'd1, 0, 1'b0, 1'b0, 1'b0, r);
    check("dep_first", r, 32'd6);
    do_op(ALU_ADD, 5'd5, 5'd4, 5'd1, 0, 1'b0, 1'b0, 1'b1, r);
    check("dep_second", r, 32'd9);

    // Reset while a response is pending
    in_valid = 1'b1; in_op = ALU_ADD; in_rd = 5'd12; in_rs1 = 5'd1; in_rs2 = 5'd4;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_out_valid", {31'b0, out_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("mid_rst_ops_done", {16'b0, ops_done}, 32'd0);
    check("mid_rst_in_ready", {31'b0, in_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
    @(posedge clk); #1;
    check("rel_in_ready", {31'b0, in_ready}, 32'd1);
    read_reg(5'd1, 32'h0, "rst_rf1");
    read_reg(5'd4, 32'h0, "rst_rf4");
    read_reg(5'd12, 32'h0, "rst_rf12");

    // Randomized traffic against the model
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 1) == 1)
        do_ld(5'($urandom_range(0, 7)), $urandom);
      do_op(2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), $urandom_range(0, 3), $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) == 0, 1'b0, r);
    end
    for (int i = 0; i < 8; i++) read_reg(5'(i), m_rf[i], "final_rf");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded its time limit");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
